timer_dev: RTL and testbench

- Memory-mapped programmable countdown timer on the CPU's peripheral bus, downstream of the `mips` core via the system bridge.
- Counts down from a software-loaded preset. Signals expiry on an `irq` line that feeds the core's external-interrupt input.
- Supports one-shot and auto-reload modes.
- Register file and control FSM are the whole block; there is no external bus protocol beyond single-cycle register access.

---
 rtl/timer_pkg.sv | 29 ++
 rtl/timer_dev_if.sv | 13 +
 rtl/timer_dev.sv | 117 +++++++++++
 tb/tb_timer_dev.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared register map, CTRL field positions, mode encodings and FSM state type for the countdown timer.
package timer_pkg;

    localparam logic [1:0] CTRL_ADDR   = 2'd0;
    localparam logic [1:0] PRESET_ADDR = 2'd1;
    localparam logic [1:0] COUNT_ADDR  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/timer_dev_if.sv
// Single-cycle peripheral register bus for the timer plus its interrupt line.
interface timer_dev_if #(
    parameter int CNT_W = 32
);
    logic [1:0]       addr;
    logic             we;
    logic [CNT_W-1:0] wdata;
    logic [CNT_W-1:0] rdata;
    logic             irq;

    modport master (output addr, output we, output wdata, input rdata, input irq);
    modport slave  (input addr, input we, input wdata, output rdata, output irq);
endinterface

// File: rtl/timer_dev.sv
// Programmable countdown timer with one-shot/auto-reload modes; writes land on the next edge, rdata is combinational.
// Latency: expiry flag N+2 edges after the EN-setting write, irq one edge later; no backpressure (always accepts).
module timer_dev
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    timer_dev_if.slave  bus
);

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             int_flag_q, int_flag_d;
    logic             irq_q, irq_d;

    logic ctrl_wr;
    logic preset_wr;
    logic fsm_set;
    logic fsm_clr_en;

    assign ctrl_wr   = bus.we && (bus.addr == CTRL_ADDR);
    assign preset_wr = bus.we && (bus.addr == PRESET_ADDR);

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            CTRL_ADDR: begin
                bus.rdata[CTRL_EN]      = ctrl_q.en;
                bus.rdata[CTRL_MODE_LO] = ctrl_q.mode[0];
                bus.rdata[CTRL_MODE_HI] = ctrl_q.mode[1];
                bus.rdata[CTRL_IM]      = ctrl_q.im;
            end
            PRESET_ADDR: bus.rdata = preset_q;
            COUNT_ADDR:  bus.rdata = count_q;
            default:     bus.rdata = '0;
        endcase
    end

    assign bus.irq = irq_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        fsm_set    = 1'b0;
        fsm_clr_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (count_q <= CNT_W'(1)) begin
                    // A preset of 0 expires exactly like a preset of 1.
                    count_d = '0;
                    fsm_set = 1'b1;
                    state_d = ST_INT;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            ST_INT: begin
                if (ctrl_q.mode == MODE_RELOAD) begin
                    state_d = ST_LOAD;
                end else begin
                    fsm_clr_en = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Software writes override the one-shot self-disable.
        ctrl_d = ctrl_q;
        if (ctrl_wr) begin
            ctrl_d.en   = bus.wdata[CTRL_EN];
            ctrl_d.mode = {bus.wdata[CTRL_MODE_HI], bus.wdata[CTRL_MODE_LO]};
            ctrl_d.im   = bus.wdata[CTRL_IM];
        end else if (fsm_clr_en) begin
            ctrl_d.en = 1'b0;
        end

        preset_d = preset_wr ? bus.wdata : preset_q;

        // An expiry coinciding with an acknowledge is kept, never lost.
        int_flag_d = fsm_set | (int_flag_q & ~ctrl_wr);
        irq_d      = ctrl_q.im & int_flag_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            int_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            int_flag_q <= int_flag_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: stimulus pushes expected rdata/irq from a behavioural model, a monitor pops and compares.
module tb_timer_dev;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    timer_dev_if #(.CNT_W(32)) bus ();

    timer_dev #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        irq;
        logic [1:0]  addr;
    } exp_t;
    exp_t sb[$];

    // Behavioural model: timer phases described in terms of what the timer is doing.
    localparam int PH_IDLE = 0;   // waiting for enable
    localparam int PH_LOAD = 1;   // copying preset into the counter
    localparam int PH_RUN  = 2;   // counting down
    localparam int PH_DONE = 3;   // just expired
    bit          m_en, m_im, m_flag, m_irq;
    bit  [1:0]   m_mode;
    bit  [31:0]  m_preset, m_count;
    int          m_phase;

    task automatic m_reset();
        m_en = 0; m_im = 0; m_flag = 0; m_irq = 0; m_mode = 0;
        m_preset = 0; m_count = 0; m_phase = PH_IDLE;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_edge(input logic we, input logic [1:0] a, input logic [31:0] d);
        bit          ctrl_w;
        bit          expire;
        bit          oneshot_done;
        int          ph;
        bit  [31:0]  cnt;
        bit          nirq;
        ctrl_w = we && (a == 2'd0);
        expire = 0;
        oneshot_done = 0;
        ph = m_phase;
        cnt = m_count;
        nirq = m_im && m_flag;
        case (m_phase)
            PH_IDLE: if (m_en) ph = PH_LOAD;
            PH_LOAD: begin cnt = m_preset; ph = PH_RUN; end
            PH_RUN: begin
                if (!m_en) ph = PH_IDLE;
                else if (m_count < 2) begin cnt = 0; expire = 1; ph = PH_DONE; end
                else cnt = m_count - 1;
            end
            default: begin
                if (m_mode == 2'b01) ph = PH_LOAD;
                else begin oneshot_done = 1; ph = PH_IDLE; end
            end
        endcase
        if (expire) m_flag = 1;
        else if (ctrl_w) m_flag = 0;
        if (ctrl_w) {m_im, m_mode, m_en} = d[3:0];
        else if (oneshot_done) m_en = 0;
        if (we && a == 2'd1) m_preset = d;
        m_phase = ph;
        m_count = cnt;
        m_irq = nirq;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: expected values come from the model state before the edge this cycle ends on.
    task automatic cyc(input logic we, input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.we = we;
        bus.addr = a;
        bus.wdata = d;
        sb.push_back('{rdata: m_read(a), irq: m_irq, addr: a});
        m_edge(we, a, d);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b1, a, d);
    endtask

    task automatic rd(input logic [1:0] a, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, a, 32'd0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("rdata[a%0d]", e.addr), bus.rdata, e.rdata);
                check("irq", {31'd0, bus.irq}, {31'd0, e.irq});
            end
        end
    end

    initial begin
        logic [1:0]  a;
        logic [31:0] d;
        bus.we = 0; bus.addr = 0; bus.wdata = 0;
        reset = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_irq", {31'd0, bus.irq}, 32'd0);
        bus.addr = 2'd2;
        #1;
        check("reset_count", bus.rdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1;

        // Register reads out of reset
        rd(2'd0, 1); rd(2'd1, 1); rd(2'd2, 1); rd(2'd3, 1);

        // One-shot with IM, then acknowledge
        wr(2'd1, 32'd5); wr(2'd0, 32'h9);
        rd(2'd2, 12); rd(2'd0, 1);
        wr(2'd0, 32'h8); rd(2'd2, 3);

        // Auto-reload, acknowledge mid-run, then stop
        wr(2'd1, 32'd3); wr(2'd0, 32'hB);
        rd(2'd2, 10); wr(2'd0, 32'hB); rd(2'd2, 10);
        wr(2'd0, 32'h0); rd(2'd2, 3);

        // Masked interrupt, then acknowledge
        wr(2'd1, 32'd4); wr(2'd0, 32'h1);
        rd(2'd2, 8); wr(2'd0, 32'h8); rd(2'd0, 3);

        // Preset rewrite while counting, disable, re-enable
        wr(2'd1, 32'd10); wr(2'd0, 32'h9);
        rd(2'd2, 5); wr(2'd1, 32'd2); wr(2'd0, 32'h8);
        rd(2'd2, 3); wr(2'd0, 32'h9); rd(2'd2, 6); wr(2'd0, 32'h8);

        // COUNT is read-only, addr 3 reads zero, preset 0 acts as 1
        wr(2'd2, 32'hFFFF); rd(2'd2, 1); rd(2'd3, 1);
        wr(2'd1, 32'd0); wr(2'd0, 32'h9); rd(2'd2, 6); wr(2'd0, 32'h0);

        // Asynchronous reset in the middle of a count
        wr(2'd1, 32'd20); wr(2'd0, 32'h9); rd(2'd2, 5);
        @(negedge clk);
        #1;
        bus.we = 0; bus.addr = 2'd2;
        reset = 0;
        #1;
        check("midrst_count", bus.rdata, 32'd0);
        check("midrst_irq", {31'd0, bus.irq}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1;
        m_reset();
        rd(2'd0, 1); rd(2'd2, 4);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                case (a)
                    2'd0:    d = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 15));
                    2'd1:    d = 32'($urandom_range(0, 6));
                    default: d = $urandom;
                endcase
                wr(a, d);
            end else begin
                rd(a, 1);
            end
        end

        repeat (3) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
